// File: rtl/alu_seq_if.sv
// Operand/result bundle between the register-file/controller side and alu_seq.
// The master drives the request fields; the slave (ALU) drives status, result and flags.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] dat1;
  logic [WIDTH-1:0] dat2;
  logic [3:0]       control;
  logic             set;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] result;
  logic             Z;
  logic             N;
  logic             C;
  logic             V;

  modport master (
    output start, dat1, dat2, control, set,
    input  busy, done, err, result, Z, N, C, V
  );

  modport slave (
    input  start, dat1, dat2, control, set,
    output busy, done, err, result, Z, N, C, V
  );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with start/done handshake, multi-cycle shift-add multiplier
// and registered NZCV flags. Single-cycle ops complete on the accepting edge.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH) + 1
) (
  input  logic       clk,
  input  logic       rst,
  alu_seq_if.slave   bus
);
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_LSL = 4'd4;
  localparam logic [3:0] OP_LSR = 4'd5;
  localparam logic [3:0] OP_AND = 4'd6;
  localparam logic [3:0] OP_ASR = 4'd7;

  localparam logic [SHW-1:0] CNT_LAST  = SHW'(WIDTH - 1);
  localparam logic [SHW-1:0] SHIFT_MAX = SHW'(WIDTH);

  typedef enum logic {IDLE, MUL} state_t;

  state_t             state;
  logic               busy;
  logic               done;
  logic               err;
  logic [WIDTH-1:0]   result;
  logic               flag_z;
  logic               flag_n;
  logic               flag_c;
  logic               flag_v;

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] mul_a;
  logic [WIDTH-1:0]   mul_b;
  logic [SHW-1:0]     cnt;
  logic               mul_set;

  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [SHW-1:0]     s;
  logic               s_in_range;
  logic [WIDTH:0]     add_w;
  logic [WIDTH:0]     sub_w;
  logic [2*WIDTH-1:0] lsl_w;
  logic [2*WIDTH-1:0] lsr_w;
  logic [2*WIDTH-1:0] asr_w;
  logic [WIDTH-1:0]   op_res;
  logic               op_c;
  logic               op_v;
  logic               op_legal;

  assign a = bus.dat1;
  assign b = bus.dat2;
  assign s = b[SHW-1:0];

  // Shifts run in a double-width window: the bit just past the kept half is
  // the last bit shifted out, so C falls out of the same shifter.
  always_comb begin
    add_w      = {1'b0, a} + {1'b0, b};
    sub_w      = {1'b0, a} - {1'b0, b};
    lsl_w      = {{WIDTH{1'b0}}, a} << s;
    lsr_w      = {a, {WIDTH{1'b0}}} >> s;
    asr_w      = $signed({a, {WIDTH{1'b0}}}) >>> s;
    s_in_range = (s != '0) && (s <= SHIFT_MAX);
    op_res     = '1;
    op_c       = 1'b0;
    op_v       = 1'b0;
    op_legal   = 1'b1;
    case (bus.control)
      OP_ADD: begin
        op_res = add_w[WIDTH-1:0];
        op_c   = add_w[WIDTH];
        op_v   = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        op_res = sub_w[WIDTH-1:0];
        op_c   = ~sub_w[WIDTH];
        op_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_MUL: op_res = '0;
      OP_OR:  op_res = a | b;
      OP_AND: op_res = a & b;
      OP_LSL: begin
        op_res = lsl_w[WIDTH-1:0];
        op_c   = s_in_range & lsl_w[WIDTH];
      end
      OP_LSR: begin
        op_res = lsr_w[2*WIDTH-1:WIDTH];
        op_c   = s_in_range & lsr_w[WIDTH-1];
      end
      OP_ASR: begin
        op_res = asr_w[2*WIDTH-1:WIDTH];
        op_c   = s_in_range & asr_w[WIDTH-1];
      end
      default: op_legal = 1'b0;
    endcase
  end

  // mul_a holds A<<cnt and mul_b holds B>>cnt, so each step tests bit 0 only.
  assign acc_next = acc + (mul_b[0] ? mul_a : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      result  <= '0;
      flag_z  <= 1'b0;
      flag_n  <= 1'b0;
      flag_c  <= 1'b0;
      flag_v  <= 1'b0;
      acc     <= '0;
      mul_a   <= '0;
      mul_b   <= '0;
      cnt     <= '0;
      mul_set <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.control == OP_MUL) begin
              state   <= MUL;
              busy    <= 1'b1;
              mul_a   <= {{WIDTH{1'b0}}, a};
              mul_b   <= b;
              acc     <= '0;
              cnt     <= '0;
              mul_set <= bus.set;
            end else begin
              done   <= 1'b1;
              err    <= ~op_legal;
              result <= op_res;
              if (bus.set && op_legal) begin
                flag_n <= op_res[WIDTH-1];
                flag_z <= (op_res == '0);
                flag_c <= op_c;
                flag_v <= op_v;
              end
            end
          end
        end
        MUL: begin
          acc   <= acc_next;
          mul_a <= mul_a << 1;
          mul_b <= mul_b >> 1;
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b1;
            err    <= 1'b0;
            result <= acc_next[WIDTH-1:0];
            if (mul_set) begin
              flag_n <= acc_next[WIDTH-1];
              flag_z <= (acc_next[WIDTH-1:0] == '0);
              flag_c <= |acc_next[2*WIDTH-1:WIDTH];
              flag_v <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy   = busy;
  assign bus.done   = done;
  assign bus.err    = err;
  assign bus.result = result;
  assign bus.Z      = flag_z;
  assign bus.N      = flag_n;
  assign bus.C      = flag_c;
  assign bus.V      = flag_v;
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: an arithmetic reference model checked every cycle,
// plus literal expectations on each directed operation.
module tb_alu_seq;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  alu_seq_if #(.WIDTH(W)) bus ();
  alu_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct packed {
    logic [31:0] res;
    logic        c;
    logic        v;
    logic        ok;
  } op_t;

  // Reference: plain integer arithmetic, shifts done one bit at a time.
  function automatic op_t model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    op_t         o;
    logic [63:0] u;
    longint      sa, sb, sv;
    int          s;
    logic [31:0] x;
    o.res = '1; o.c = 1'b0; o.v = 1'b0; o.ok = 1'b1;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    s  = int'(b[5:0]);
    x  = a;
    case (op)
      4'd0: begin
        u = 64'(a) + 64'(b); o.res = u[31:0]; o.c = u[32];
        sv = sa + sb; o.v = (sv != longint'($signed(o.res)));
      end
      4'd1: begin
        u = 64'(a) - 64'(b); o.res = u[31:0]; o.c = (a >= b);
        sv = sa - sb; o.v = (sv != longint'($signed(o.res)));
      end
      4'd2: begin
        u = 64'(a) * 64'(b); o.res = u[31:0]; o.c = (u[63:32] != 0);
      end
      4'd3: o.res = a | b;
      4'd6: o.res = a & b;
      4'd4, 4'd5, 4'd7: begin
        for (int i = 0; i < s; i++) begin
          if (op == 4'd4) begin o.c = x[31]; x = {x[30:0], 1'b0}; end
          else if (op == 4'd5) begin o.c = x[0]; x = {1'b0, x[31:1]}; end
          else begin o.c = x[0]; x = {x[31], x[31:1]}; end
        end
        if (s > 32) o.c = 1'b0;
        o.res = x;
      end
      default: o.ok = 1'b0;
    endcase
    return o;
  endfunction

  op_t         cur;
  logic [63:0] mprod;
  logic        exp_busy = 0, exp_done = 0, exp_err = 0;
  logic [31:0] exp_res = '0;
  logic [3:0]  exp_nzcv = '0;
  int          mul_left = 0;
  logic [31:0] m_a = '0, m_b = '0;
  logic        m_set = 0;

  always_comb begin
    cur   = model_op(bus.control, bus.dat1, bus.dat2);
    mprod = 64'(m_a) * 64'(m_b);
  end

  always @(posedge clk) begin
    if (rst) begin
      exp_busy <= 0; exp_done <= 0; exp_err <= 0; exp_res <= '0; exp_nzcv <= '0;
      mul_left <= 0;
    end else begin
      exp_done <= 0;
      if (mul_left > 0) begin
        mul_left <= mul_left - 1;
        if (mul_left == 1) begin
          exp_done <= 1; exp_busy <= 0; exp_err <= 0; exp_res <= mprod[31:0];
          if (m_set) exp_nzcv <= {mprod[31], mprod[31:0] == 0, mprod[63:32] != 0, 1'b0};
        end
      end else if (bus.start) begin
        if (bus.control == 4'd2) begin
          mul_left <= W; exp_busy <= 1;
          m_a <= bus.dat1; m_b <= bus.dat2; m_set <= bus.set;
        end else begin
          exp_done <= 1;
          exp_err  <= !cur.ok;
          exp_res  <= cur.ok ? cur.res : 32'hFFFF_FFFF;
          if (bus.set && cur.ok) exp_nzcv <= {cur.res[31], cur.res == 0, cur.c, cur.v};
        end
      end
    end
  end

  always @(negedge clk) begin
    check("cyc.done",   64'(bus.done),   64'(exp_done));
    check("cyc.busy",   64'(bus.busy),   64'(exp_busy));
    check("cyc.err",    64'(bus.err),    64'(exp_err));
    check("cyc.result", 64'(bus.result), 64'(exp_res));
    check("cyc.nzcv",   64'({bus.N, bus.Z, bus.C, bus.V}), 64'(exp_nzcv));
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic st);
    bus.start = 1'b1; bus.control = op; bus.dat1 = a; bus.dat2 = b; bus.set = st;
    @(posedge clk); #2;
    bus.start = 1'b0;
  endtask

  task automatic lit(input string nm, input logic [31:0] r, input logic [3:0] f, input logic e);
    check({nm, ".done"},   64'(bus.done),   64'd1);
    check({nm, ".result"}, 64'(bus.result), 64'(r));
    check({nm, ".nzcv"},   64'({bus.N, bus.Z, bus.C, bus.V}), 64'(f));
    check({nm, ".err"},    64'(bus.err),    64'(e));
  endtask

  // Counts edges from accept (edge 1) to the edge after which done is high.
  task automatic wait_done(output int edges, input bit poke);
    edges = 1;
    while (bus.done !== 1'b1 && edges < 40) begin
      bus.start   = poke && (edges == 5 || edges == 20);
      bus.control = 4'd0;
      bus.dat1    = 32'h1234_5678;
      @(posedge clk); #2;
      edges++;
    end
    bus.start = 1'b0;
  endtask

  int edges;
  localparam logic [31:0] SA = 32'h8000_0001;

  initial begin
    bus.start = 0; bus.dat1 = '0; bus.dat2 = '0; bus.control = '0; bus.set = 0;
    repeat (3) @(posedge clk);
    #2;
    check("reset.outputs", 64'({bus.busy, bus.done, bus.err, bus.N, bus.Z, bus.C, bus.V}), 64'd0);
    check("reset.result",  64'(bus.result), 64'd0);
    rst = 1'b0;

    issue(4'd0, 32'hFFFF_FFFF, 32'h1, 1);             lit("add_carry", 32'h0, 4'b0110, 0);
    issue(4'd1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1);     lit("sub_ovf", 32'h8000_0000, 4'b1001, 0);
    issue(4'd0, 32'd3, 32'd4, 0);                     lit("add_noset", 32'd7, 4'b1001, 0);

    issue(4'd2, 32'h0001_0000, 32'h0001_0000, 1);
    check("mul_big.busy", 64'(bus.busy), 64'd1);
    wait_done(edges, 1'b1);
    check("mul_big.latency", 64'(edges), 64'd33);
    lit("mul_big", 32'h0, 4'b0110, 0);
    @(posedge clk); #2;
    check("mul_big.single_done", 64'(bus.done), 64'd0);

    issue(4'd2, 32'd7, 32'd6, 1);
    wait_done(edges, 1'b0);
    check("mul_small.latency", 64'(edges), 64'd33);
    lit("mul_small", 32'd42, 4'b0000, 0);

    issue(4'd4, SA, 32'd1, 1);                        lit("lsl1", 32'h2, 4'b0010, 0);
    issue(4'd5, SA, 32'd32, 1);                       lit("lsr32", 32'h0, 4'b0110, 0);
    issue(4'd7, SA, 32'd40, 1);                       lit("asr40", 32'hFFFF_FFFF, 4'b1000, 0);
    issue(4'd5, SA, 32'd0, 1);                        lit("lsr0", SA, 4'b1000, 0);
    issue(4'd4, SA, 32'd32, 1);                       lit("lsl32", 32'h0, 4'b0110, 0);
    issue(4'd7, SA, 32'd4, 1);                        lit("asr4", 32'hF800_0000, 4'b1000, 0);
    issue(4'd5, SA, 32'hFFFF_FF01, 1);                lit("lsr_hi_ignored", 32'h4000_0000, 4'b0010, 0);
    issue(4'd6, 32'hF0F0_F0F0, 32'hFF00_FF00, 1);     lit("and", 32'hF000_F000, 4'b1000, 0);
    issue(4'd3, 32'h0, 32'h0, 1);                     lit("or_zero", 32'h0, 4'b0100, 0);
    issue(4'd12, 32'd5, 32'd6, 1);                    lit("illegal", 32'hFFFF_FFFF, 4'b0100, 1);
    issue(4'd0, 32'd1, 32'd1, 1);                     lit("add_after_err", 32'd2, 4'b0000, 0);

    issue(4'd2, 32'h0000_FFFF, 32'h0000_FFFF, 1);
    repeat (8) begin @(posedge clk); #2; end
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    check("rst_mid_mul.outputs", 64'({bus.busy, bus.done, bus.err, bus.N, bus.Z, bus.C, bus.V}), 64'd0);
    check("rst_mid_mul.result",  64'(bus.result), 64'd0);
    issue(4'd0, 32'd3, 32'd4, 1);                     lit("add_after_rst", 32'd7, 4'b0000, 0);

    repeat (40) @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
